// File: rtl/csr_regfile_pkg.sv
// Shared CSR addresses, field positions and WARL helpers for the machine-mode register file.
package csr_regfile_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [31:0] MISA_VALUE    = 32'h4000_1100;
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

    function automatic logic csr_writable(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: csr_writable = 1'b1;
            default:                                              csr_writable = 1'b0;
        endcase
    endfunction

    // Value a writable CSR will read back after storing wdata.
    function automatic logic [31:0] warl_view(input logic [11:0] addr, input logic [31:0] wdata);
        case (addr)
            CSR_MSTATUS: warl_view = (wdata & MSTATUS_WMASK) | {19'b0, PRIV_M, 11'b0};
            CSR_MIE:     warl_view = wdata & MIE_WMASK;
            CSR_MTVEC:   warl_view = wdata & MTVEC_WMASK;
            CSR_MEPC:    warl_view = wdata & MEPC_WMASK;
            default:     warl_view = wdata;
        endcase
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// CSR read/write bus between the execute/write-back stages (master) and the register file (slave).
interface csr_regfile_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i;
    logic [DATA_WIDTH-1:0]     csr_rdata_o;
    logic                      csr_we_i;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i;
    logic [DATA_WIDTH-1:0]     csr_wdata_i;

    modport master (
        output csr_raddr_i,
        input  csr_rdata_o,
        output csr_we_i,
        output csr_waddr_i,
        output csr_wdata_i
    );

    modport slave (
        input  csr_raddr_i,
        output csr_rdata_o,
        input  csr_we_i,
        input  csr_waddr_i,
        input  csr_wdata_i
    );
endinterface

// File: rtl/csr_counter64.sv
// Wide free-running counter with independent low/high write ports; a write wins over the increment.
module csr_counter64 #(
    parameter int HALF_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                wr_lo_i,
    input  logic                wr_hi_i,
    input  logic [HALF_W-1:0]   wdata_i,
    output logic [2*HALF_W-1:0] cnt_o
);
    logic [2*HALF_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d = {cnt_q[2*HALF_W-1:HALF_W], wdata_i};
        end else if (wr_hi_i) begin
            cnt_d = {wdata_i, cnt_q[HALF_W-1:0]};
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational read with write bypass, 64-bit counters, interrupt pending and trap/mret updates.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int HART_ID        = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    csr_regfile_if.slave          csr_bus,
    input  logic                  instret_i,
    input  logic                  timer_irq_i,
    input  logic                  ext_irq_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_cause_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic                  mret_i,
    output logic [DATA_WIDTH-1:0] mtvec_o,
    output logic [DATA_WIDTH-1:0] mepc_o,
    output logic                  irq_pending_o
);
    logic [CSR_ADDR_WIDTH-1:0] raddr, waddr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      we;

    assign raddr = csr_bus.csr_raddr_i;
    assign waddr = csr_bus.csr_waddr_i;
    assign wdata = csr_bus.csr_wdata_i;
    assign we    = csr_bus.csr_we_i;

    logic                  mstatus_mie_q, mstatus_mie_d;
    logic                  mstatus_mpie_q, mstatus_mpie_d;
    logic [DATA_WIDTH-1:0] mie_q, mie_d;
    logic [DATA_WIDTH-1:0] mip_q, mip_d;
    logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d;
    logic [DATA_WIDTH-1:0] mscratch_q, mscratch_d;
    logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
    logic [DATA_WIDTH-1:0] mcause_q, mcause_d;

    logic [2*DATA_WIDTH-1:0] mcycle, minstret;
    logic [DATA_WIDTH-1:0]   mstatus_rd;

    logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause;

    assign we_mstatus  = we && (waddr == CSR_MSTATUS);
    assign we_mie      = we && (waddr == CSR_MIE);
    assign we_mtvec    = we && (waddr == CSR_MTVEC);
    assign we_mscratch = we && (waddr == CSR_MSCRATCH);
    assign we_mepc     = we && (waddr == CSR_MEPC);
    assign we_mcause   = we && (waddr == CSR_MCAUSE);

    // Per-register priority: trap entry, then CSR write, then mret.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        if (trap_i) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (we_mstatus) begin
            mstatus_mie_d  = wdata[MSTATUS_MIE];
            mstatus_mpie_d = wdata[MSTATUS_MPIE];
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        mepc_d = mepc_q;
        if (trap_i) begin
            mepc_d = trap_pc_i & MEPC_WMASK;
        end else if (we_mepc) begin
            mepc_d = wdata & MEPC_WMASK;
        end

        mcause_d = mcause_q;
        if (trap_i) begin
            mcause_d = trap_cause_i;
        end else if (we_mcause) begin
            mcause_d = wdata;
        end

        mie_d      = we_mie      ? (wdata & MIE_WMASK)   : mie_q;
        mtvec_d    = we_mtvec    ? (wdata & MTVEC_WMASK) : mtvec_q;
        mscratch_d = we_mscratch ? wdata                 : mscratch_q;

        mip_d           = '0;
        mip_d[MIP_MTIP] = timer_irq_i;
        mip_d[MIP_MEIP] = ext_irq_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

    csr_counter64 #(.HALF_W(DATA_WIDTH)) u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .wr_lo_i (we && (waddr == CSR_MCYCLE)),
        .wr_hi_i (we && (waddr == CSR_MCYCLEH)),
        .wdata_i (wdata),
        .cnt_o   (mcycle)
    );

    csr_counter64 #(.HALF_W(DATA_WIDTH)) u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instret_i),
        .wr_lo_i (we && (waddr == CSR_MINSTRET)),
        .wr_hi_i (we && (waddr == CSR_MINSTRETH)),
        .wdata_i (wdata),
        .cnt_o   (minstret)
    );

    assign mstatus_rd = {19'b0, PRIV_M, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

    // Same-cycle write to the addressed CSR is forwarded in its stored (masked) form.
    always_comb begin
        csr_bus.csr_rdata_o = '0;
        case (raddr)
            CSR_MSTATUS:                 csr_bus.csr_rdata_o = mstatus_rd;
            CSR_MISA:                    csr_bus.csr_rdata_o = MISA_VALUE;
            CSR_MIE:                     csr_bus.csr_rdata_o = mie_q;
            CSR_MTVEC:                   csr_bus.csr_rdata_o = mtvec_q;
            CSR_MSCRATCH:                csr_bus.csr_rdata_o = mscratch_q;
            CSR_MEPC:                    csr_bus.csr_rdata_o = mepc_q;
            CSR_MCAUSE:                  csr_bus.csr_rdata_o = mcause_q;
            CSR_MIP:                     csr_bus.csr_rdata_o = mip_q;
            CSR_MCYCLE, CSR_CYCLE:       csr_bus.csr_rdata_o = mcycle[DATA_WIDTH-1:0];
            CSR_MCYCLEH, CSR_CYCLEH:     csr_bus.csr_rdata_o = mcycle[2*DATA_WIDTH-1:DATA_WIDTH];
            CSR_MINSTRET, CSR_INSTRET:   csr_bus.csr_rdata_o = minstret[DATA_WIDTH-1:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_bus.csr_rdata_o = minstret[2*DATA_WIDTH-1:DATA_WIDTH];
            CSR_MHARTID:                 csr_bus.csr_rdata_o = DATA_WIDTH'(HART_ID);
            default:                     csr_bus.csr_rdata_o = '0;
        endcase
        if (we && (waddr == raddr) && csr_writable(waddr)) begin
            csr_bus.csr_rdata_o = warl_view(waddr, wdata);
        end
    end

    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign irq_pending_o = mstatus_mie_q & |(mie_q & mip_q);
endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: counters, WARL writes and bypass, trap/mret priority, interrupts and async reset.
module tb_csr_regfile;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        instret_i, timer_irq_i, ext_irq_i, trap_i, mret_i;
    logic [31:0] trap_cause_i, trap_pc_i;
    logic [31:0] mtvec_o, mepc_o;
    logic        irq_pending_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] d;
    logic [31:0] d2;

    csr_regfile_if #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

    csr_regfile #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12), .HART_ID(0)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .csr_bus       (bus),
        .instret_i     (instret_i),
        .timer_irq_i   (timer_irq_i),
        .ext_irq_i     (ext_irq_i),
        .trap_i        (trap_i),
        .trap_cause_i  (trap_cause_i),
        .trap_pc_i     (trap_pc_i),
        .mret_i        (mret_i),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o),
        .irq_pending_o (irq_pending_o)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        bus.csr_raddr_i = a;
        #1;
        v = bus.csr_rdata_o;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = a;
        bus.csr_wdata_i = v;
        tick();
        bus.csr_we_i    = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (mtvec_o !== 32'h0) begin bad++; $display("FAIL reset_mtvec: got %h want %h", mtvec_o, 32'h0); end
        total++; if (irq_pending_o !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq_pending_o); end
        rd(12'h300, d);
        total++; if (d !== 32'h0000_1800) begin bad++; $display("FAIL reset_mstatus: got %h want %h", d, 32'h1800); end
        rd(12'hB00, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mcycle: got %h want %h", d, 32'h0); end
        rst_i = 1'b1;
        repeat (10) tick();
        rd(12'hB00, d);
        total++; if (d !== 32'd10) begin bad++; $display("FAIL idle_mcycle: got %h want %h", d, 32'd10); end
        rd(12'hC80, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL idle_cycleh: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_instret();
        instret_i = 1'b1;
        repeat (3) tick();
        instret_i = 1'b0;
        tick();
        rd(12'hB02, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL minstret: got %h want %h", d, 32'd3); end
        rd(12'hC02, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL instret_shadow: got %h want %h", d, 32'd3); end
    endtask

    task automatic test_write_bypass();
        bus.csr_raddr_i = 12'h305;
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = 12'h305;
        bus.csr_wdata_i = 32'h8000_0100;
        #1;
        total++; if (bus.csr_rdata_o !== 32'h8000_0100) begin bad++; $display("FAIL bypass_mtvec: got %h want %h", bus.csr_rdata_o, 32'h80000100); end
        total++; if (mtvec_o !== 32'h0) begin bad++; $display("FAIL mtvec_before_edge: got %h want %h", mtvec_o, 32'h0); end
        tick();
        bus.csr_we_i = 1'b0;
        total++; if (mtvec_o !== 32'h8000_0100) begin bad++; $display("FAIL mtvec_o: got %h want %h", mtvec_o, 32'h80000100); end
        wr(12'h305, 32'h8000_0103);
        rd(12'h305, d);
        total++; if (d !== 32'h8000_0100) begin bad++; $display("FAIL mtvec_warl: got %h want %h", d, 32'h80000100); end
        // masked bypass on mstatus, and no bypass for read-only misa
        bus.csr_raddr_i = 12'h300;
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = 12'h300;
        bus.csr_wdata_i = 32'hFFFF_FFFF;
        #1;
        total++; if (bus.csr_rdata_o !== 32'h0000_1888) begin bad++; $display("FAIL bypass_mstatus: got %h want %h", bus.csr_rdata_o, 32'h1888); end
        bus.csr_raddr_i = 12'h301;
        bus.csr_waddr_i = 12'h301;
        bus.csr_wdata_i = 32'h0;
        #1;
        total++; if (bus.csr_rdata_o !== 32'h4000_1100) begin bad++; $display("FAIL misa_no_bypass: got %h want %h", bus.csr_rdata_o, 32'h40001100); end
        tick();
        bus.csr_we_i = 1'b0;
        rd(12'h301, d);
        total++; if (d !== 32'h4000_1100) begin bad++; $display("FAIL misa_ro: got %h want %h", d, 32'h40001100); end
        wr(12'h304, 32'hFFFF_FFFF);
        rd(12'h304, d);
        total++; if (d !== 32'h0000_0888) begin bad++; $display("FAIL mie_warl: got %h want %h", d, 32'h888); end
        wr(12'h340, 32'hDEAD_BEEF);
        rd(12'h340, d);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mscratch: got %h want %h", d, 32'hDEADBEEF); end
        wr(12'h341, 32'h0000_0203);
        rd(12'h341, d);
        total++; if (d !== 32'h0000_0200) begin bad++; $display("FAIL mepc_warl: got %h want %h", d, 32'h200); end
        wr(12'h123, 32'h1234_5678);
        rd(12'h123, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unimpl: got %h want %h", d, 32'h0); end
        rd(12'hF14, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mhartid: got %h want %h", d, 32'h0); end
        wr(12'h300, 32'h0);
        wr(12'h304, 32'h0);
    endtask

    task automatic test_counter_carry();
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0);
        rd(12'hB00, d);
        rd(12'hB80, d2);
        total++; if ({d2, d} !== 64'h0000_0000_FFFF_FFFF) begin bad++; $display("FAIL carry_pre: got %h_%h want 00000000_ffffffff", d2, d); end
        tick();
        rd(12'hB00, d);
        rd(12'hB80, d2);
        total++; if ({d2, d} !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL carry_post: got %h_%h want 00000001_00000000", d2, d); end
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, d);
        rd(12'hB80, d2);
        total++; if ({d2, d} !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL wrap_pre: got %h_%h want ffffffff_ffffffff", d2, d); end
        tick();
        rd(12'hB00, d);
        rd(12'hB80, d2);
        total++; if ({d2, d} !== 64'h0) begin bad++; $display("FAIL wrap_post: got %h_%h want 00000000_00000000", d2, d); end
        wr(12'hB02, 32'hFFFF_FFFF);
        wr(12'hB82, 32'h0);
        instret_i = 1'b1;
        tick();
        instret_i = 1'b0;
        rd(12'hB02, d);
        rd(12'hC82, d2);
        total++; if ({d2, d} !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL instret_carry: got %h_%h want 00000001_00000000", d2, d); end
    endtask

    task automatic test_trap_mret();
        wr(12'h300, 32'h0000_1808);
        rd(12'h300, d);
        total++; if (d !== 32'h0000_1808) begin bad++; $display("FAIL mstatus_set: got %h want %h", d, 32'h1808); end
        trap_i       = 1'b1;
        trap_pc_i    = 32'h0000_0102;
        trap_cause_i = 32'h8000_000B;
        tick();
        trap_i = 1'b0;
        total++; if (mepc_o !== 32'h0000_0100) begin bad++; $display("FAIL trap_mepc: got %h want %h", mepc_o, 32'h100); end
        rd(12'h342, d);
        total++; if (d !== 32'h8000_000B) begin bad++; $display("FAIL trap_mcause: got %h want %h", d, 32'h8000000B); end
        rd(12'h300, d);
        total++; if (d !== 32'h0000_1880) begin bad++; $display("FAIL trap_mstatus: got %h want %h", d, 32'h1880); end
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        rd(12'h300, d);
        total++; if (d !== 32'h0000_1888) begin bad++; $display("FAIL mret_mstatus: got %h want %h", d, 32'h1888); end
    endtask

    task automatic test_simultaneous();
        // mstatus is 0x1888 on entry
        trap_i          = 1'b1;
        trap_pc_i       = 32'h0000_0304;
        trap_cause_i    = 32'h0000_0005;
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = 12'h341;
        bus.csr_wdata_i = 32'h0000_0200;
        tick();
        trap_i       = 1'b0;
        bus.csr_we_i = 1'b0;
        total++; if (mepc_o !== 32'h0000_0304) begin bad++; $display("FAIL trap_vs_write_mepc: got %h want %h", mepc_o, 32'h304); end
        rd(12'h300, d);
        total++; if (d !== 32'h0000_1880) begin bad++; $display("FAIL trap_vs_write_mstatus: got %h want %h", d, 32'h1880); end
        trap_i       = 1'b1;
        mret_i       = 1'b1;
        trap_pc_i    = 32'h0000_0400;
        trap_cause_i = 32'h0000_0003;
        tick();
        trap_i = 1'b0;
        mret_i = 1'b0;
        rd(12'h300, d);
        total++; if (d !== 32'h0000_1800) begin bad++; $display("FAIL trap_vs_mret: got %h want %h", d, 32'h1800); end
        rd(12'h342, d);
        total++; if (d !== 32'h0000_0003) begin bad++; $display("FAIL trap_vs_mret_cause: got %h want %h", d, 32'h3); end
        trap_i          = 1'b1;
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = 12'h300;
        bus.csr_wdata_i = 32'h0000_0088;
        tick();
        trap_i       = 1'b0;
        bus.csr_we_i = 1'b0;
        rd(12'h300, d);
        total++; if (d !== 32'h0000_1800) begin bad++; $display("FAIL trap_vs_write_status: got %h want %h", d, 32'h1800); end
        total++; if (mepc_o !== 32'h0000_0400) begin bad++; $display("FAIL trap_mepc2: got %h want %h", mepc_o, 32'h400); end
    endtask

    task automatic test_interrupts();
        wr(12'h304, 32'h0000_0080);
        wr(12'h300, 32'h0000_0008);
        timer_irq_i = 1'b1;
        rd(12'h344, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mip_latency: got %h want %h", d, 32'h0); end
        total++; if (irq_pending_o !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq_pending_o); end
        tick();
        rd(12'h344, d);
        total++; if (d !== 32'h0000_0080) begin bad++; $display("FAIL mip_mtip: got %h want %h", d, 32'h80); end
        total++; if (irq_pending_o !== 1'b1) begin bad++; $display("FAIL irq_timer: got %b want 1", irq_pending_o); end
        timer_irq_i = 1'b0;
        ext_irq_i   = 1'b1;
        tick();
        rd(12'h344, d);
        total++; if (d !== 32'h0000_0800) begin bad++; $display("FAIL mip_meip: got %h want %h", d, 32'h800); end
        total++; if (irq_pending_o !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", irq_pending_o); end
        timer_irq_i = 1'b1;
        tick();
        total++; if (irq_pending_o !== 1'b1) begin bad++; $display("FAIL irq_again: got %b want 1", irq_pending_o); end
        #3;
        rst_i = 1'b0;
        #1;
        total++; if (mtvec_o !== 32'h0) begin bad++; $display("FAIL midreset_mtvec: got %h want %h", mtvec_o, 32'h0); end
        total++; if (mepc_o !== 32'h0) begin bad++; $display("FAIL midreset_mepc: got %h want %h", mepc_o, 32'h0); end
        total++; if (irq_pending_o !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", irq_pending_o); end
        rd(12'hB00, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_mcycle: got %h want %h", d, 32'h0); end
        rd(12'h300, d);
        total++; if (d !== 32'h0000_1800) begin bad++; $display("FAIL midreset_mstatus: got %h want %h", d, 32'h1800); end
        timer_irq_i = 1'b0;
        ext_irq_i   = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    initial begin
        rst_i           = 1'b0;
        instret_i       = 1'b0;
        timer_irq_i     = 1'b0;
        ext_irq_i       = 1'b0;
        trap_i          = 1'b0;
        mret_i          = 1'b0;
        trap_cause_i    = 32'h0;
        trap_pc_i       = 32'h0;
        bus.csr_raddr_i = 12'h0;
        bus.csr_we_i    = 1'b0;
        bus.csr_waddr_i = 12'h0;
        bus.csr_wdata_i = 32'h0;

        test_reset();
        test_instret();
        test_write_bypass();
        test_counter_carry();
        test_trap_mret();
        test_simultaneous();
        test_interrupts();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
